// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the board reset sequencer.
// The FSM states are IDLE, HOLD and RELEASE.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } state_t;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronises and debounces the raw reset button.
// Emits a one-cycle press pulse when the debounced level rises.
module debounce_filter
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  output logic btn_level_o,
  output logic press_evt
);

  localparam int            CW           = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_MAX       = CW'(DEBOUNCE_CYCLES);
  localparam logic          RELEASED_RAW = BTN_ACTIVE_LOW;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          pressed;

  // Normalise polarity so that 1 always means pressed.
  assign pressed = sync[1] ^ RELEASED_RAW;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync        <= {2{RELEASED_RAW}};
      cnt         <= '0;
      btn_level_o <= 1'b0;
      press_evt   <= 1'b0;
    end else begin
      sync      <= {sync[0], btn_i};
      press_evt <= 1'b0;
      if (pressed == btn_level_o) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        btn_level_o <= pressed;
        press_evt   <= pressed;
        cnt         <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset generator: asserts all channels on a button press or software
// request, holds them, then releases channel 0 upward with a fixed stagger.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int HOLD_CYCLES     = 100_000,
  parameter int STAGGER_CYCLES  = 1000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                btn_i,
  input  logic                sw_req_i,
  output logic [CHANNELS-1:0] rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                btn_level_o
);

  localparam int            HW        = cnt_width(HOLD_CYCLES);
  localparam int            SW        = cnt_width(STAGGER_CYCLES);
  localparam int            IW        = cnt_width(CHANNELS);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STG_LOAD  = SW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(CHANNELS - 1);

  state_t              state, state_next;
  logic [HW-1:0]       hold_cnt, hold_next;
  logic [SW-1:0]       stg_cnt, stg_next;
  logic [IW-1:0]       idx, idx_next;
  logic [CHANNELS-1:0] rst_next;
  logic                done_next;
  logic                press_evt;
  logic                trigger;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_debounce (
    .CLK        (CLK),
    .RST        (RST),
    .btn_i      (btn_i),
    .btn_level_o(btn_level_o),
    .press_evt  (press_evt)
  );

  assign trigger = press_evt | sw_req_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    stg_next   = stg_cnt;
    idx_next   = idx;
    rst_next   = rst_o;
    done_next  = 1'b0;

    // A trigger overrides any release scheduled for this cycle.
    if (trigger) begin
      state_next = HOLD;
      hold_next  = HOLD_LOAD;
      idx_next   = '0;
      rst_next   = '1;
    end else begin
      case (state)
        IDLE: ;
        HOLD: begin
          if (hold_cnt == '0) begin
            rst_next[0] = 1'b0;
            if (CHANNELS == 1) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = RELEASE;
              idx_next   = IW'(1);
              stg_next   = STG_LOAD;
            end
          end else begin
            hold_next = hold_cnt - HW'(1);
          end
        end
        RELEASE: begin
          if (stg_cnt == '0) begin
            for (int c = 0; c < CHANNELS; c++) begin
              if (idx == IW'(c)) rst_next[c] = 1'b0;
            end
            if (idx == LAST_IDX) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              idx_next = idx + IW'(1);
              stg_next = STG_LOAD;
            end
          end else begin
            stg_next = stg_cnt - SW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Reset drops straight into a full hold so power-on runs the normal sequence.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= HOLD;
      hold_cnt <= HOLD_LOAD;
      stg_cnt  <= '0;
      idx      <= '0;
      rst_o    <= '1;
      busy_o   <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      stg_cnt  <= stg_next;
      idx      <= idx_next;
      rst_o    <= rst_next;
      busy_o   <= |rst_next;
      done_o   <= done_next;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short timing parameters:
// power-on, bounce, button press, software request, retrigger, long press, RST mid-hold.
module tb_reset_sequencer;

  logic       CLK;
  logic       RST;
  logic       btn_i;
  logic       sw_req_i;
  logic [2:0] rst_o;
  logic       busy_o;
  logic       done_o;
  logic       btn_level_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  reset_sequencer #(
    .CHANNELS       (3),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (4),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .btn_i      (btn_i),
    .sw_req_i   (sw_req_i),
    .rst_o      (rst_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .btn_level_o(btn_level_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just after the edge that entered HOLD (k=0).
  // Bit0 drops 16 edges later, bit1 at +4, bit2 at +8 with done_o for that cycle.
  task automatic seq(input string tag, input int upto);
    logic [2:0] exp_rst;
    for (int k = 0; k <= upto; k++) begin
      if (k > 0) @(negedge CLK);
      if (k < 16)      exp_rst = 3'b111;
      else if (k < 20) exp_rst = 3'b110;
      else if (k < 24) exp_rst = 3'b100;
      else             exp_rst = 3'b000;
      check({tag, "_rst"},  32'(rst_o), 32'(exp_rst));
      check({tag, "_done"}, 32'(done_o), 32'(k == 24));
      check({tag, "_busy"}, 32'(busy_o), 32'(|exp_rst));
    end
  endtask

  initial begin
    RST      = 1'b1;
    btn_i    = 1'b1;
    sw_req_i = 1'b0;

    // Power-on reset held for five edges.
    repeat (5) begin
      @(negedge CLK);
      check("por_rst",   32'(rst_o), 32'h7);
      check("por_busy",  32'(busy_o), 32'h1);
      check("por_done",  32'(done_o), 32'h0);
      check("por_level", 32'(btn_level_o), 32'h0);
    end
    RST = 1'b0;
    seq("por", 25);

    // Bouncing contact never stays stable long enough.
    btn_i = 1'b0; repeat (5) @(negedge CLK);
    btn_i = 1'b1; repeat (2) @(negedge CLK);
    btn_i = 1'b0; repeat (5) @(negedge CLK);
    btn_i = 1'b1;
    repeat (16) begin
      @(negedge CLK);
      check("bounce_rst",   32'(rst_o), 32'h0);
      check("bounce_level", 32'(btn_level_o), 32'h0);
    end

    // Steady press: level rises 11 edges after the pin, rst_o one edge later.
    btn_i = 1'b0;
    repeat (10) @(negedge CLK);
    check("press_lvl_early", 32'(btn_level_o), 32'h0);
    @(negedge CLK);
    check("press_lvl",   32'(btn_level_o), 32'h1);
    check("press_rst_0", 32'(rst_o), 32'h0);
    @(negedge CLK);
    seq("btn", 25);

    // Keep holding: no further sequence.
    repeat (160) begin
      @(negedge CLK);
      check("long_rst", 32'(rst_o), 32'h0);
    end
    btn_i = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      check("unpress_rst", 32'(rst_o), 32'h0);
    end
    check("unpress_level", 32'(btn_level_o), 32'h0);

    // Software request from IDLE.
    check("sw_idle", 32'(rst_o), 32'h0);
    sw_req_i = 1'b1;
    @(negedge CLK);
    sw_req_i = 1'b0;
    seq("sw", 25);

    // Retrigger after bit0 has released.
    sw_req_i = 1'b1;
    @(negedge CLK);
    sw_req_i = 1'b0;
    seq("rtg_a", 17);
    sw_req_i = 1'b1;
    @(negedge CLK);
    sw_req_i = 1'b0;
    seq("rtg_b", 25);

    // Button press and software request sampled on the same edge.
    btn_i = 1'b0;
    repeat (11) @(negedge CLK);
    check("sim_lvl", 32'(btn_level_o), 32'h1);
    sw_req_i = 1'b1;
    @(negedge CLK);
    sw_req_i = 1'b0;
    seq("sim", 25);
    btn_i = 1'b1;
    repeat (15) @(negedge CLK);
    check("sim_unpress_lvl", 32'(btn_level_o), 32'h0);
    check("sim_unpress_rst", 32'(rst_o), 32'h0);

    // RST in the middle of HOLD restarts the full hold.
    sw_req_i = 1'b1;
    @(negedge CLK);
    sw_req_i = 1'b0;
    seq("mid_pre", 5);
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("mid_rst",  32'(rst_o), 32'h7);
      check("mid_busy", 32'(busy_o), 32'h1);
      check("mid_done", 32'(done_o), 32'h0);
    end
    RST = 1'b0;
    seq("mid_post", 25);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
